// File: rtl/grf_scoreboard.sv
// Issue-side scoreboard for the GRF: per-register pending-write counters,
// RAW/WAW hazard stall generation and a drain handshake for exception entry.
module grf_scoreboard #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs,
   input  logic            issue_use_rs,
   input  logic [AW-1:0]   issue_rt,
   input  logic            issue_use_rt,
   input  logic            issue_wr,
   input  logic [AW-1:0]   issue_dst,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_dst,
   input  logic            drain_req,
   output logic            stall,
   output logic            issue_fire,
   output logic [NREG-1:0] busy,
   output logic            drain_ack,
   output logic            err_uflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                      state_reg;
   state_t                      state_next;
   logic [NREG-1:0][CNT_W-1:0]  cnt_reg;
   logic [NREG-1:0][CNT_W-1:0]  cnt_next;
   logic [NREG-1:0]             uflow_vec;
   logic                        err_uflow_reg;

   logic [CNT_W-1:0] cnt_rs;
   logic [CNT_W-1:0] cnt_rt;
   logic [CNT_W-1:0] cnt_dst;
   logic             hit_rs;
   logic             hit_rt;
   logic             raw;
   logic             waw_ful;

   assign cnt_rs  = cnt_reg[issue_rs];
   assign cnt_rt  = cnt_reg[issue_rt];
   assign cnt_dst = cnt_reg[issue_dst];

   // A source whose only pending write retires this cycle is served by the GRF bypass.
   assign hit_rs = (issue_rs != '0) && (cnt_rs != '0) &&
                   !(wb_valid && (wb_dst == issue_rs) && (cnt_rs == CNT_ONE));
   assign hit_rt = (issue_rt != '0) && (cnt_rt != '0) &&
                   !(wb_valid && (wb_dst == issue_rt) && (cnt_rt == CNT_ONE));

   assign raw     = (issue_use_rs & hit_rs) | (issue_use_rt & hit_rt);
   assign waw_ful = issue_wr && (issue_dst != '0) && (cnt_dst == CNT_MAX) &&
                    !(wb_valid && (wb_dst == issue_dst));

   assign stall      = issue_valid & (raw | waw_ful | (state_reg != ST_RUN));
   assign issue_fire = issue_valid & ~stall;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign cnt_next[gi]  = '0;
            assign uflow_vec[gi] = 1'b0;
         end else begin : g_cnt
            logic inc;
            logic dec;
            assign inc = issue_fire & issue_wr & (issue_dst == AW'(gi));
            assign dec = wb_valid & (wb_dst == AW'(gi));
            assign cnt_next[gi] =
               (inc & ~dec)                        ? cnt_reg[gi] + CNT_ONE :
               (dec & ~inc & (cnt_reg[gi] != '0))  ? cnt_reg[gi] - CNT_ONE :
                                                     cnt_reg[gi];
            assign uflow_vec[gi] = dec & ~inc & (cnt_reg[gi] == '0);
         end
         assign busy[gi] = |cnt_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg       <= '0;
         state_reg     <= ST_RUN;
         err_uflow_reg <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
         if (|uflow_vec) begin
            err_uflow_reg <= 1'b1;
         end
      end
   end

   // Drain completes once every counter is zero after this cycle's update.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN: begin
            if (drain_req) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!drain_req) begin
               state_next = ST_RUN;
            end else if (cnt_next == '0) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!drain_req) begin
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   assign drain_ack = (state_reg == ST_DONE);
   assign err_uflow = err_uflow_reg;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed plus randomized bench for grf_scoreboard against a count-per-register model.
module tb_grf_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic        issue_use_rs;
   logic [4:0]  issue_rt;
   logic        issue_use_rt;
   logic        issue_wr;
   logic [4:0]  issue_dst;
   logic        wb_valid;
   logic [4:0]  wb_dst;
   logic        drain_req;
   logic        stall;
   logic        issue_fire;
   logic [31:0] busy;
   logic        drain_ack;
   logic        err_uflow;

   grf_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_rs     (issue_rs),
      .issue_use_rs (issue_use_rs),
      .issue_rt     (issue_rt),
      .issue_use_rt (issue_use_rt),
      .issue_wr     (issue_wr),
      .issue_dst    (issue_dst),
      .wb_valid     (wb_valid),
      .wb_dst       (wb_dst),
      .drain_req    (drain_req),
      .stall        (stall),
      .issue_fire   (issue_fire),
      .busy         (busy),
      .drain_ack    (drain_ack),
      .err_uflow    (err_uflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: outstanding writes per register, sticky error, drain phase
   // (0 = running, 1 = waiting for writes to retire, 2 = acknowledged).
   int mcnt [32];
   bit merr;
   int mph;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      merr = 1'b0;
      mph  = 0;
   endfunction

   function automatic bit src_blocked(input int r);
      if (r == 0 || mcnt[r] == 0) return 1'b0;
      if (wb_valid && int'(wb_dst) == r && mcnt[r] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_stall();
      bit raw_h, waw_h;
      raw_h = (issue_use_rs && src_blocked(int'(issue_rs))) ||
              (issue_use_rt && src_blocked(int'(issue_rt)));
      waw_h = issue_wr && issue_dst != 0 && mcnt[issue_dst] == 3 &&
              !(wb_valid && wb_dst == issue_dst);
      return issue_valid && (raw_h || waw_h || mph != 0);
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
      return b;
   endfunction

   task automatic idle();
      issue_valid = 0; issue_rs = 0; issue_use_rs = 0; issue_rt = 0; issue_use_rt = 0;
      issue_wr = 0; issue_dst = 0; wb_valid = 0; wb_dst = 0;
   endtask

   task automatic set_issue(input int rs, input bit urs, input int rt, input bit urt,
                            input bit wr, input int dst);
      issue_valid = 1; issue_rs = 5'(rs); issue_use_rs = urs; issue_rt = 5'(rt);
      issue_use_rt = urt; issue_wr = wr; issue_dst = 5'(dst);
   endtask

   // One clock: check outputs mid-cycle, then advance the model on the edge.
   task automatic step(input string tag);
      bit es, ef;
      bit all_zero;
      @(negedge clk);
      es = exp_stall();
      ef = issue_valid && !es;
      chk({tag, ".stall"}, 32'(stall), 32'(es));
      chk({tag, ".fire"}, 32'(issue_fire), 32'(ef));
      chk({tag, ".busy"}, busy, exp_busy());
      chk({tag, ".ack"}, 32'(drain_ack), 32'(mph == 2));
      chk({tag, ".err"}, 32'(err_uflow), 32'(merr));
      @(posedge clk);
      if (ef && issue_wr && issue_dst != 0) mcnt[issue_dst]++;
      if (wb_valid && wb_dst != 0) begin
         if (mcnt[wb_dst] > 0) mcnt[wb_dst]--;
         else merr = 1'b1;
      end
      all_zero = 1'b1;
      for (int i = 0; i < 32; i++) if (mcnt[i] != 0) all_zero = 1'b0;
      case (mph)
         0: if (drain_req) mph = 1;
         1: if (!drain_req) mph = 0; else if (all_zero) mph = 2;
         default: if (!drain_req) mph = 0;
      endcase
      #1;
   endtask

   initial begin
      int cands[$];
      model_reset();
      idle();
      drain_req = 0;
      reset = 0;
      #12;
      chk("reset.busy", busy, 32'h0);
      chk("reset.ack", 32'(drain_ack), 32'h0);
      chk("reset.err", 32'(err_uflow), 32'h0);
      set_issue(8, 1, 9, 1, 1, 8);
      #1;
      chk("reset.stall", 32'(stall), 32'h0);
      idle();
      @(posedge clk); #1;
      reset = 1;

      // RAW hazard on $8 resolved through the writeback bypass
      set_issue(1, 1, 2, 0, 1, 8);  step("t1.wr8");
      set_issue(8, 1, 0, 0, 0, 0);  step("t1.raw_a");
      step("t1.raw_b");
      wb_valid = 1; wb_dst = 8;     step("t1.bypass");
      idle();                       step("t1.idle");
      chk("t1.busy8", 32'(busy[8]), 32'h0);

      // WAW counter saturation on $9
      set_issue(0, 0, 0, 0, 1, 9);
      step("t2.i1"); step("t2.i2"); step("t2.i3");
      chk("t2.busy9", 32'(busy[9]), 32'h1);
      step("t2.full");
      wb_valid = 1; wb_dst = 9;     step("t2.full_wb");
      idle(); wb_valid = 1; wb_dst = 9;
      step("t2.wb1"); step("t2.wb2"); step("t2.wb3");
      idle();                       step("t2.empty");

      // register zero is never tracked
      set_issue(0, 1, 0, 1, 1, 0);
      step("t3.a"); step("t3.b"); step("t3.c");
      chk("t3.busy0", 32'(busy[0]), 32'h0);

      // writeback underflow is sticky
      idle(); wb_valid = 1; wb_dst = 5;  step("t4.uflow");
      idle();                            step("t4.sticky");
      chk("t4.busy5", 32'(busy[5]), 32'h0);

      // drain with two outstanding writes to $3
      set_issue(0, 0, 0, 0, 1, 3);  step("t5.w1"); step("t5.w2");
      drain_req = 1;
      set_issue(1, 1, 0, 0, 0, 0);  step("t5.rise");
      step("t5.blocked");
      wb_valid = 1; wb_dst = 3;     step("t5.wb1"); step("t5.wb2");
      wb_valid = 0;                 step("t5.done");
      chk("t5.ack", 32'(drain_ack), 32'h1);
      drain_req = 0;                step("t5.drop");
      step("t5.resume");

      // asynchronous reset in the middle of a drain
      idle();
      set_issue(0, 0, 0, 0, 1, 4);  step("t6.w4");
      idle(); drain_req = 1;        step("t6.req");
      step("t6.draining");
      #2;
      reset = 0;
      #1;
      model_reset();
      chk("t6.busy", busy, 32'h0);
      chk("t6.ack", 32'(drain_ack), 32'h0);
      chk("t6.err", 32'(err_uflow), 32'h0);
      drain_req = 0;
      @(posedge clk); #1;
      reset = 1;
      step("t6.after");

      // randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         issue_valid  = 1'($urandom_range(0, 1));
         issue_rs     = 5'($urandom_range(0, 7));
         issue_use_rs = 1'($urandom_range(0, 1));
         issue_rt     = 5'($urandom_range(0, 7));
         issue_use_rt = 1'($urandom_range(0, 1));
         issue_wr     = 1'($urandom_range(0, 1));
         issue_dst    = 5'($urandom_range(0, 7));
         cands.delete();
         for (int i = 1; i < 32; i++) if (mcnt[i] > 0) cands.push_back(i);
         wb_valid = 1'($urandom_range(0, 1));
         if (cands.size() > 0 && $urandom_range(0, 7) != 0)
            wb_dst = 5'(cands[$urandom_range(0, cands.size() - 1)]);
         else
            wb_dst = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
